// File: rtl/mips_pkg.sv
// Definitions shared between the interrupt generator and the mips top level:
// register offsets, CTRL bit positions, FSM states and the acknowledge address.
package mips_pkg;

    localparam logic [31:0] INT_ACK_ADDR = 32'h0000_7F20;

    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_PRESET = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_MASK     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_t;

endpackage

// File: rtl/int_gen_regs.sv
// Bus-side register file for int_gen: window decode, byte-enabled CTRL/PRESET
// writes and the combinational read mux over all four registers.
module int_gen_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = INT_ACK_ADDR,
    parameter int unsigned MISS_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              en_clr,
    input  logic              pending,
    input  logic [MISS_W-1:0] missed,
    input  logic [31:0]       count,
    output logic              en,
    output logic              periodic,
    output logic              mask,
    output logic [31:0]       preset,
    output logic              status_wr,
    output logic              en_after_wr,
    output logic              en_on_wr,
    output logic              en_off_wr
);

    logic       in_win;
    logic       wr;
    logic [3:0] off;
    logic       ctrl_wr;
    logic       unused_addr_bits;

    assign in_win           = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr               = in_win && (byteen != 4'b0000);
    assign off              = {addr[3:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];

    assign status_wr   = wr && (off == OFF_STATUS);
    assign ctrl_wr     = wr && (off == OFF_CTRL) && byteen[0];
    assign en_on_wr    = ctrl_wr && wdata[CTRL_EN];
    assign en_off_wr   = ctrl_wr && !wdata[CTRL_EN];
    assign en_after_wr = ctrl_wr ? wdata[CTRL_EN] : en;

    // A CTRL write in the same cycle as a one-shot fire overrides the en clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            mask     <= 1'b0;
            preset   <= '0;
        end else begin
            if (ctrl_wr) begin
                en       <= wdata[CTRL_EN];
                periodic <= wdata[CTRL_PERIODIC];
                mask     <= wdata[CTRL_MASK];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr && (off == OFF_PRESET) && byteen[b])
                    preset[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (off)
                OFF_STATUS: begin
                    rdata[0]            = pending;
                    rdata[8 +: MISS_W]  = missed;
                end
                OFF_CTRL: begin
                    rdata[CTRL_EN]       = en;
                    rdata[CTRL_PERIODIC] = periodic;
                    rdata[CTRL_MASK]     = mask;
                end
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/int_gen.sv
// Memory-mapped external interrupt generator: a preset down-counter that raises
// a level interrupt on expiry, held until the CPU acknowledges it.
module int_gen
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = INT_ACK_ADDR,
    parameter int unsigned MISS_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] int_addr,
    input  logic [3:0]  int_byteen,
    output logic        irq
);

    state_t            state, state_n;
    logic [31:0]       count, count_n;
    logic              pending, pending_n;
    logic [MISS_W-1:0] missed, missed_n;
    logic              en_clr;
    logic              en, periodic, mask;
    logic [31:0]       preset;
    logic              status_wr, en_after_wr, en_on_wr, en_off_wr;
    logic              ack;

    int_gen_regs #(
        .BASE_ADDR(BASE_ADDR),
        .MISS_W   (MISS_W)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .byteen     (byteen),
        .wdata      (wdata),
        .rdata      (rdata),
        .en_clr     (en_clr),
        .pending    (pending),
        .missed     (missed),
        .count      (count),
        .en         (en),
        .periodic   (periodic),
        .mask       (mask),
        .preset     (preset),
        .status_wr  (status_wr),
        .en_after_wr(en_after_wr),
        .en_on_wr   (en_on_wr),
        .en_off_wr  (en_off_wr)
    );

    assign ack = ((int_addr == BASE_ADDR) && (int_byteen != 4'b0000)) || status_wr;
    assign irq = pending & mask;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            pending <= 1'b0;
            missed  <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pending <= pending_n;
            missed  <= missed_n;
        end
    end

    // A disabling CTRL write freezes count and suppresses any fire in that cycle.
    always_comb begin
        state_n   = state;
        count_n   = count;
        pending_n = ack ? 1'b0 : pending;
        missed_n  = missed;
        en_clr    = 1'b0;
        if (en_off_wr) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en_after_wr)
                        state_n = LOAD;
                end
                LOAD: begin
                    count_n = preset;
                    state_n = COUNT;
                end
                COUNT: begin
                    if (count > 32'd1) begin
                        count_n = count - 32'd1;
                    end else begin
                        count_n   = '0;
                        pending_n = 1'b1;
                        if (pending && !ack && (missed != '1))
                            missed_n = missed + 1'b1;
                        if (periodic || en_on_wr) begin
                            state_n = LOAD;
                        end else begin
                            en_clr  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
